if_fetch_unit: RTL

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction fetch stage. Issues one request at a time to instruction
//   memory, buffers returned words with their PCs in a 2-entry FIFO and
//   presents the FIFO head to the decode stage. A redirect flushes the FIFO
//   and restarts fetching at the jump target. A request that is still in
//   flight when a redirect arrives is allowed to complete, and its response
//   is thrown away.
//
// Parameters
//   PC_RESET    fetch address loaded at reset
//   PC_STEP     fetch-address increment per instruction
//
// Ports
//   clock        in   single clock, rising edge
//   reset        in   asynchronous, active-high reset
//   imem_req     out  request outstanding
//   imem_addr    out  request address, stable while imem_req is high
//   imem_ack     in   memory accepted the request; imem_rdata valid this cycle
//   imem_rdata   in   fetched instruction word
//   hold         in   decode stage cannot accept this cycle
//   redirect     in   taken jump/branch; refetch from redirect_pc
//   redirect_pc  in   jump target
//   PC           out  PC of the instruction presented to decode (0 if empty)
//   inst         out  instruction presented to decode (0 if empty)
//   valid        out  PC/inst valid (FIFO non-empty)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        hold,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] PC,
    output logic [15:0] inst,
    output logic        valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] fpc;
    logic [15:0] disc_addr;
    logic [15:0] fifo_pc   [2];
    logic [15:0] fifo_inst [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic        push;
    logic        pop;

    assign valid = (count != 2'd0);
    assign pop   = valid & ~hold;
    // A redirect cancels the response arriving in the same cycle.
    assign push  = (state == REQ) & imem_ack & ~redirect;

    // A new request is only issued when count_next < 2, so at most one entry
    // is occupied whenever a push can happen and this never exceeds 2.
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    assign PC   = valid ? fifo_pc[rd_ptr]   : 16'h0000;
    assign inst = valid ? fifo_inst[rd_ptr] : 16'h0000;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (redirect || (count_next < 2'd2)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    // With ack the old request is finished, so refetch at
                    // once; otherwise wait out the in-flight response.
                    state_next = imem_ack ? REQ : DISCARD;
                end else if (imem_ack) begin
                    state_next = (count_next < 2'd2) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fpc;
        case (state)
            REQ:     imem_req = 1'b1;
            DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = disc_addr;
            end
            default: imem_req = 1'b0;
        endcase
    end

    // Control state: fetch PC and FIFO occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fpc    <= PC_RESET;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (redirect) begin
            fpc    <= redirect_pc;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            count <= count_next;
            if (push) begin
                fpc    <= fpc + PC_STEP;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // FIFO storage and abandoned-request address; contents only matter
    // while qualified by count or the DISCARD state, so no reset is needed.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= fpc;
            fifo_inst[wr_ptr] <= imem_rdata;
        end
        if ((state == REQ) && redirect && !imem_ack) begin
            disc_addr <= fpc;
        end
    end

endmodule
